johnson_phase_monitor: RTL and testbench
========================================

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

Interface
REQ-001 Parameter: LOCK_CNT, default 2, consecutive successor steps needed to enter LOCKED (range 1..7).
REQ-002 Parameter: LAP_W, default 8, width of lap counter.
REQ-003 Parameter: ERR_W, default 4, width of saturating error counter.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: en  input  1  sample enable; when 0 all registers hold and pulses are 0.
REQ-007 Port: q  input  3  Johnson counter state under observation.
REQ-008 Port: clr_err  input  1  synchronous clear of err_cnt.
REQ-009 Port: phase_oh  output  6  one-hot decoded phase, registered.
REQ-010 Port: phase_idx  output  3  binary decoded phase, 7 when code illegal.
REQ-011 Port: code_valid  output  1  last sampled code is legal.
REQ-012 Port: locked  output  1  high while FSM is in LOCKED.
REQ-013 Port: seq_err  output  1  one-cycle pulse, legal but wrong transition while LOCKED.
REQ-014 Port: ill_err  output  1  one-cycle pulse, illegal code sampled (any state).
REQ-015 Port: lap_pulse  output  1  one-cycle pulse on each 100->000 step while LOCKED.
REQ-016 Port: lap_cnt  output  LAP_W  count of laps, wraps modulo 2^LAP_W.
REQ-017 Port: err_cnt  output  ERR_W  count of seq_err plus ill_err events, saturating.

Function
REQ-018 Code map SHALL be 000->0, 001->1, 011->2, 111->3, 110->4, 100->5; 010 and 101 illegal.
REQ-019 On each en=1 edge: q_s<=q; phase_idx/phase_oh/code_valid<=decode(q); latency one cycle from q.
REQ-020 Illegal code: phase_idx=7, phase_oh=000000, code_valid=0.
REQ-021 Step classification uses previous sample q_s and current q: SUCC (q=successor(q_s), incl. 100->000), HOLD (q=q_s), BAD (other legal), ILL (q illegal).
REQ-022 FSM states SHALL be HUNT, TRACK, LOCKED; classification is evaluated only when en=1.
REQ-023 HUNT: legal q -> TRACK with good_cnt=0; ILL -> stay HUNT, ill_err=1.
REQ-024 TRACK: SUCC increments good_cnt, and at good_cnt+1=LOCK_CNT -> LOCKED; HOLD -> no change; BAD -> good_cnt=0, stay TRACK, no error pulse; ILL -> HUNT, ill_err=1.
REQ-025 LOCKED: SUCC stays; HOLD stays; BAD -> HUNT, seq_err=1; ILL -> HUNT, ill_err=1.
REQ-026 LOCKED with SUCC step 100->000 SHALL assert lap_pulse and increment lap_cnt (wrapping max->0).
REQ-027 Each seq_err or ill_err pulse SHALL increment err_cnt, holding at 2^ERR_W-1.
REQ-028 clr_err=1 SHALL set err_cnt to 0, or to 1 if an error pulse occurs on the same edge; clr_err acts regardless of en.
REQ-029 seq_err and ill_err SHALL never assert together; lap_pulse never with either.
REQ-030 The first sample after reset has no q_s reference and SHALL be treated as entry from HUNT only.

Reset
REQ-031 reset=1 SHALL immediately force: FSM=HUNT, good_cnt=0, q_s=000, phase_idx=0, phase_oh=000001, code_valid=0, locked=0, all pulses 0, lap_cnt=0, err_cnt=0.
REQ-032 Reset asserted mid-lap or while LOCKED SHALL discard lock; relock requires a fresh HUNT->TRACK->LOCKED sequence.
REQ-033 Deassertion SHALL take effect on the next rising clk with no extra wait cycles.

Verification
REQ-034 en=1, q steps 000,001,011,111,110,100,000 after reset -> phase_idx 0..5,0; locked rises after 2nd SUCC step; lap_pulse once, lap_cnt=1.
REQ-035 While LOCKED at 011, drive 110 -> seq_err one cycle, locked=0, err_cnt=1, FSM HUNT.
REQ-036 Drive 010 in any state -> ill_err one cycle, phase_idx=7, phase_oh=0, code_valid=0, err_cnt increments.
REQ-037 17 illegal codes with ERR_W=4 -> err_cnt=15 held; clr_err with simultaneous ill_err -> err_cnt=1.
REQ-038 en=0 for 5 cycles while q changes arbitrarily -> all outputs frozen, no pulses; HOLD steps while LOCKED keep locked=1.
REQ-039 Assert reset asynchronously between edges while LOCKED, lap_cnt=3 -> outputs reach REQ-031 values before next edge.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// Watches a 3-bit Johnson counter: decodes its phase, tracks lock onto the
// legal successor sequence, and counts laps and sequencing/illegal-code errors.
module johnson_phase_monitor #(
   parameter int LOCK_CNT = 2,
   parameter int LAP_W    = 8,
   parameter int ERR_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       q,
   input  logic             clr_err,
   output logic [5:0]       phase_oh,
   output logic [2:0]       phase_idx,
   output logic             code_valid,
   output logic             locked,
   output logic             seq_err,
   output logic             ill_err,
   output logic             lap_pulse,
   output logic [LAP_W-1:0] lap_cnt,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

   localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

   state_t           state, stateNext;
   logic [2:0]       goodCnt, goodCntNext;
   logic [2:0]       qS;
   logic             legal, isSucc, isHold;
   logic [2:0]       decIdx;
   logic [5:0]       decOh;
   logic             seqNext, illNext, lapNext, errInc;
   logic [ERR_W-1:0] errNext;

   // Phase decode of the live input; 010 and 101 are the two illegal codes
   always_comb begin
      decIdx = 3'd7;
      decOh  = 6'b000000;
      legal  = 1'b1;
      case (q)
         3'b000: begin decIdx = 3'd0; decOh = 6'b000001; end
         3'b001: begin decIdx = 3'd1; decOh = 6'b000010; end
         3'b011: begin decIdx = 3'd2; decOh = 6'b000100; end
         3'b111: begin decIdx = 3'd3; decOh = 6'b001000; end
         3'b110: begin decIdx = 3'd4; decOh = 6'b010000; end
         3'b100: begin decIdx = 3'd5; decOh = 6'b100000; end
         default: legal = 1'b0;
      endcase
   end

   // Johnson successor is a left shift feeding back the inverted MSB
   assign isSucc = legal && (q == {qS[1:0], ~qS[2]});
   assign isHold = legal && (q == qS);

   always_comb begin
      stateNext   = state;
      goodCntNext = goodCnt;
      seqNext     = 1'b0;
      illNext     = 1'b0;
      lapNext     = 1'b0;
      if (en) begin
         case (state)
            HUNT: begin
               if (!legal) begin
                  illNext = 1'b1;
               end else begin
                  stateNext   = TRACK;
                  goodCntNext = 3'd0;
               end
            end
            TRACK: begin
               if (!legal) begin
                  stateNext   = HUNT;
                  illNext     = 1'b1;
                  goodCntNext = 3'd0;
               end else if (isSucc) begin
                  if (goodCnt + 3'd1 == LOCK_TGT) begin
                     stateNext   = LOCKED;
                     goodCntNext = 3'd0;
                  end else begin
                     goodCntNext = goodCnt + 3'd1;
                  end
               end else if (!isHold) begin
                  goodCntNext = 3'd0;
               end
            end
            LOCKED: begin
               if (!legal) begin
                  stateNext = HUNT;
                  illNext   = 1'b1;
               end else if (isSucc) begin
                  lapNext = (qS == 3'b100);
               end else if (!isHold) begin
                  stateNext = HUNT;
                  seqNext   = 1'b1;
               end
            end
            default: stateNext = HUNT;
         endcase
      end
   end

   // A clear coinciding with a new error leaves that error counted
   assign errInc = seqNext | illNext;
   always_comb begin
      errNext = err_cnt;
      if (clr_err)
         errNext = errInc ? ERR_W'(1) : '0;
      else if (errInc && (err_cnt != {ERR_W{1'b1}}))
         errNext = err_cnt + ERR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         goodCnt    <= 3'd0;
         qS         <= 3'b000;
         phase_idx  <= 3'd0;
         phase_oh   <= 6'b000001;
         code_valid <= 1'b0;
         seq_err    <= 1'b0;
         ill_err    <= 1'b0;
         lap_pulse  <= 1'b0;
         lap_cnt    <= '0;
         err_cnt    <= '0;
      end else begin
         seq_err   <= seqNext;
         ill_err   <= illNext;
         lap_pulse <= lapNext;
         err_cnt   <= errNext;
         if (en) begin
            state      <= stateNext;
            goodCnt    <= goodCntNext;
            qS         <= q;
            phase_idx  <= decIdx;
            phase_oh   <= decOh;
            code_valid <= legal;
            if (lapNext)
               lap_cnt <= lap_cnt + LAP_W'(1);
         end
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed vector bench for johnson_phase_monitor: a table of hand-computed
// steps followed by reset, saturation and clear corner sequences.
module tb_johnson_phase_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [2:0] q;
   logic       clr_err;
   logic [5:0] phase_oh;
   logic [2:0] phase_idx;
   logic       code_valid, locked, seq_err, ill_err, lap_pulse;
   logic [7:0] lap_cnt;
   logic [3:0] err_cnt;

   int applied = 0;
   int miscompares = 0;

   typedef struct {
      logic        en;
      logic [2:0]  q;
      logic        clr;
      logic [25:0] exp;
   } vec_t;

   vec_t vecs[$];

   johnson_phase_monitor #(.LOCK_CNT(2), .LAP_W(8), .ERR_W(4)) dut (
      .clk(clk), .reset(reset), .en(en), .q(q), .clr_err(clr_err),
      .phase_oh(phase_oh), .phase_idx(phase_idx), .code_valid(code_valid),
      .locked(locked), .seq_err(seq_err), .ill_err(ill_err),
      .lap_pulse(lap_pulse), .lap_cnt(lap_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [25:0] mk(input int idx, input bit cv, input bit lk,
                                      input bit se, input bit ie, input bit lp,
                                      input int lap, input int err);
      logic [5:0] oh;
      oh = (idx == 7) ? 6'b000000 : 6'b000001 << idx;
      return {3'(idx), oh, cv, lk, se, ie, lp, 8'(lap), 4'(err)};
   endfunction

   task automatic addVec(input bit e, input logic [2:0] qq, input bit c, input int idx,
                         input bit cv, input bit lk, input bit se, input bit ie,
                         input bit lp, input int lap, input int err);
      vec_t v;
      v.en = e; v.q = qq; v.clr = c;
      v.exp = mk(idx, cv, lk, se, ie, lp, lap, err);
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input bit e, input logic [2:0] qq, input bit c);
      @(negedge clk);
      en = e; q = qq; clr_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [25:0] exp);
      logic [25:0] act;
      act = {phase_idx, phase_oh, code_valid, locked, seq_err, ill_err,
             lap_pulse, lap_cnt, err_cnt};
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got idx=%0d oh=%b cv=%b lk=%b se=%b ie=%b lp=%b lap=%0d err=%0d, want idx=%0d oh=%b cv=%b lk=%b se=%b ie=%b lp=%b lap=%0d err=%0d",
                  name, act[25:23], act[22:17], act[16], act[15], act[14], act[13], act[12], act[11:4], act[3:0],
                  exp[25:23], exp[22:17], exp[16], exp[15], exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; q = 3'b000; clr_err = 1'b0;

      //     en  q       clr idx cv lk se ie lp lap err
      addVec(1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 3'b001, 0,  1, 1, 0, 0, 0, 0, 0, 0);
      addVec(1, 3'b011, 0,  2, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 3'b111, 0,  3, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 3'b110, 0,  4, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 3'b100, 0,  5, 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 3'b000, 0,  0, 1, 1, 0, 0, 1, 1, 0);
      addVec(1, 3'b000, 0,  0, 1, 1, 0, 0, 0, 1, 0);
      addVec(1, 3'b001, 0,  1, 1, 1, 0, 0, 0, 1, 0);
      addVec(1, 3'b011, 0,  2, 1, 1, 0, 0, 0, 1, 0);
      addVec(1, 3'b110, 0,  4, 1, 0, 1, 0, 0, 1, 1);
      addVec(1, 3'b110, 0,  4, 1, 0, 0, 0, 0, 1, 1);
      addVec(1, 3'b010, 0,  7, 0, 0, 0, 1, 0, 1, 2);
      addVec(1, 3'b101, 0,  7, 0, 0, 0, 1, 0, 1, 3);
      addVec(1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 1, 3);
      addVec(1, 3'b011, 0,  2, 1, 0, 0, 0, 0, 1, 3);
      addVec(1, 3'b111, 0,  3, 1, 0, 0, 0, 0, 1, 3);
      addVec(1, 3'b111, 0,  3, 1, 0, 0, 0, 0, 1, 3);
      addVec(1, 3'b110, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(0, 3'b010, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(0, 3'b101, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(0, 3'b000, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(0, 3'b011, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(0, 3'b111, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(1, 3'b110, 0,  4, 1, 1, 0, 0, 0, 1, 3);
      addVec(1, 3'b100, 0,  5, 1, 1, 0, 0, 0, 1, 3);
      addVec(1, 3'b000, 0,  0, 1, 1, 0, 0, 1, 2, 3);
      addVec(0, 3'b000, 1,  0, 1, 1, 0, 0, 0, 2, 0);
      addVec(1, 3'b010, 0,  7, 0, 0, 0, 1, 0, 2, 1);
      addVec(1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 2, 1);
      addVec(1, 3'b001, 0,  1, 1, 0, 0, 0, 0, 2, 1);
      addVec(1, 3'b011, 0,  2, 1, 1, 0, 0, 0, 2, 1);
      addVec(1, 3'b111, 0,  3, 1, 1, 0, 0, 0, 2, 1);
      addVec(1, 3'b110, 0,  4, 1, 1, 0, 0, 0, 2, 1);
      addVec(1, 3'b100, 0,  5, 1, 1, 0, 0, 0, 2, 1);
      addVec(1, 3'b000, 0,  0, 1, 1, 0, 0, 1, 3, 1);

      #2;
      checkOutput("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].q, vecs[i].clr);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Asynchronous reset mid-cycle while locked with a lap pulse active
      #2 reset = 1'b1;
      #1 checkOutput("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1, 3'b000, 0);
      checkOutput("relock_hunt", mk(0, 1, 0, 0, 0, 0, 0, 0));
      applyStimulus(1, 3'b001, 0);
      checkOutput("relock_track", mk(1, 1, 0, 0, 0, 0, 0, 0));
      applyStimulus(1, 3'b011, 0);
      checkOutput("relock_locked", mk(2, 1, 1, 0, 0, 0, 0, 0));

      // Error counter saturation and clear-with-error corner
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1, 3'b010, 0);
         checkOutput($sformatf("sat%0d", i), mk(7, 0, 0, 0, 1, 0, 0, (i + 1 > 15) ? 15 : i + 1));
      end
      applyStimulus(1, 3'b101, 1);
      checkOutput("clr_with_ill", mk(7, 0, 0, 0, 1, 0, 0, 1));
      applyStimulus(1, 3'b000, 1);
      checkOutput("clr_plain", mk(0, 1, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
